mux_rgb_capas: RTL and testbench

MUX_RGB_CAPAS -- requirements
Module: mux_rgb_capas

---
 rtl/mux_rgb_pkg.sv | 19 +
 rtl/mux_rgb_capas_if.sv | 47 ++++
 rtl/mux_rgb_capas_codificador_prioridad.sv | 37 +++
 rtl/mux_rgb_capas.sv | 166 ++++++++++++++++
 tb/tb_mux_rgb_capas.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/mux_rgb_pkg.sv
//------------------------------------------------------------------------------
// Module   : mux_rgb_pkg
// Purpose  : Shared defaults and colour constants for the RGB layer mux.
//            Nothing in this package has ports.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mux_rgb_pkg;

  localparam int          c_n_capas          = 4;
  localparam int          c_ancho_rgb        = 8;
  localparam int          c_periodo_parpadeo = 30;
  localparam logic [7:0]  c_fondo_inicial    = 8'hFF;      // white
  localparam logic [7:0]  c_color_canasta    = 8'b00111111;

endpackage : mux_rgb_pkg

`default_nettype wire

// File: rtl/mux_rgb_capas_if.sv
//------------------------------------------------------------------------------
// Module   : mux_rgb_capas_if
// Purpose  : Pixel-side bundle of the RGB layer mux.
//   Driven by the master : video_on, frame_tick, capa_activa, color_capa,
//                          parpadeo_en, fondo_wr, fondo_color
//   Driven by the slave  : rgb_salida, capa_id, colision, colision_frame
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mux_rgb_capas_if
  import mux_rgb_pkg::*;
#(
  parameter int N_CAPAS   = c_n_capas,
  parameter int ANCHO_RGB = c_ancho_rgb
) ();

  localparam int c_ancho_id = $clog2(N_CAPAS + 1);

  logic                          video_on;
  logic                          frame_tick;
  logic [N_CAPAS-1:0]            capa_activa;
  logic [N_CAPAS*ANCHO_RGB-1:0]  color_capa;
  logic [N_CAPAS-1:0]            parpadeo_en;
  logic                          fondo_wr;
  logic [ANCHO_RGB-1:0]          fondo_color;

  logic [ANCHO_RGB-1:0]          rgb_salida;
  logic [c_ancho_id-1:0]         capa_id;
  logic                          colision;
  logic                          colision_frame;

  modport master (
    output video_on, frame_tick, capa_activa, color_capa, parpadeo_en,
           fondo_wr, fondo_color,
    input  rgb_salida, capa_id, colision, colision_frame
  );

  modport slave (
    input  video_on, frame_tick, capa_activa, color_capa, parpadeo_en,
           fondo_wr, fondo_color,
    output rgb_salida, capa_id, colision, colision_frame
  );

endinterface : mux_rgb_capas_if

`default_nettype wire

// File: rtl/mux_rgb_capas_codificador_prioridad.sv
//------------------------------------------------------------------------------
// Module   : codificador_prioridad
// Purpose  : Combinational fixed-priority encoder, lowest index wins.
//   activa   in  N_CAPAS   layer hit vector
//   indice   out ANCHO_ID  winning index, N_CAPAS when no bit is set
//   hay_capa out 1         at least one bit set
//   multiple out 1         two or more bits set
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module codificador_prioridad
  import mux_rgb_pkg::*;
#(
  parameter int N_CAPAS  = c_n_capas,
  parameter int ANCHO_ID = $clog2(N_CAPAS + 1)
) (
  input  logic [N_CAPAS-1:0]  activa,
  output logic [ANCHO_ID-1:0] indice,
  output logic                hay_capa,
  output logic                multiple
);

  always_comb begin
    indice = ANCHO_ID'(N_CAPAS);
    // Scan downwards so the lowest set bit is the last assignment.
    for (int i = N_CAPAS - 1; i >= 0; i--) begin
      if (activa[i]) indice = ANCHO_ID'(i);
    end
    hay_capa = |activa;
    // Clearing the lowest set bit leaves something only if two or more were set.
    multiple = |(activa & (activa - N_CAPAS'(1)));
  end

endmodule : codificador_prioridad

`default_nettype wire

// File: rtl/mux_rgb_capas.sv
//------------------------------------------------------------------------------
// Module   : mux_rgb_capas
// Purpose  : Two-stage layer compositor with double-buffered background,
//            collision flags and optional per-layer blinking.
//   clk    in  pixel clock
//   reset  in  synchronous active-high reset
//   bus    slave modport of mux_rgb_capas_if (pixel inputs, composited out)
// Config   : define MUX_RGB_PARPADEO_EN to build the blink counter/phase;
//            otherwise parpadeo_en is ignored and every layer is visible.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_rgb_capas
  import mux_rgb_pkg::*;
#(
  parameter int                   N_CAPAS          = c_n_capas,
  parameter int                   ANCHO_RGB        = c_ancho_rgb,
  parameter int                   PERIODO_PARPADEO = c_periodo_parpadeo,
  // All ones at any width; matches c_fondo_inicial at the default width.
  parameter logic [ANCHO_RGB-1:0] FONDO_INICIAL    = '1
) (
  input  wire           clk,
  input  wire           reset,
  mux_rgb_capas_if.slave bus
);

  localparam int c_ancho_id = $clog2(N_CAPAS + 1);

  // Stage 1: registered pixel inputs (layer hits already blink-masked)
  logic                          r_video_s1;
  logic [N_CAPAS-1:0]            r_activa_s1;
  logic [N_CAPAS*ANCHO_RGB-1:0]  r_color_s1;

  // Stage 2: registered outputs
  logic [ANCHO_RGB-1:0]          r_rgb;
  logic [c_ancho_id-1:0]         r_id;
  logic                          r_colision;

  logic                          r_colision_frame;
  logic                          r_latch_colision;
  logic [ANCHO_RGB-1:0]          r_fondo_sombra;
  logic [ANCHO_RGB-1:0]          r_fondo_activo;

  logic [N_CAPAS-1:0]            w_visible;
  logic [c_ancho_id-1:0]         w_indice;
  logic                          w_hay_capa;
  logic                          w_multiple;
  logic [ANCHO_RGB-1:0]          w_color_ganador;
  logic [ANCHO_RGB-1:0]          w_rgb_next;
  logic [c_ancho_id-1:0]         w_id_next;
  logic                          w_col_next;

`ifdef MUX_RGB_PARPADEO_EN
  logic [7:0] r_cuenta_frame;
  logic       r_fase;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cuenta_frame <= '0;
      r_fase         <= 1'b0;
    end else if (bus.frame_tick) begin
      if (r_cuenta_frame == 8'(PERIODO_PARPADEO - 1)) begin
        r_cuenta_frame <= '0;
        r_fase         <= ~r_fase;
      end else begin
        r_cuenta_frame <= r_cuenta_frame + 8'd1;
      end
    end
  end

  // Blinking layers drop out during the hidden phase.
  assign w_visible = r_fase ? ~bus.parpadeo_en : '1;
`else
  assign w_visible = '1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_video_s1  <= 1'b0;
      r_activa_s1 <= '0;
      r_color_s1  <= '0;
    end else begin
      r_video_s1  <= bus.video_on;
      r_activa_s1 <= bus.capa_activa & w_visible;
      r_color_s1  <= bus.color_capa;
    end
  end

  codificador_prioridad #(
    .N_CAPAS  (N_CAPAS),
    .ANCHO_ID (c_ancho_id)
  ) u_codificador (
    .activa   (r_activa_s1),
    .indice   (w_indice),
    .hay_capa (w_hay_capa),
    .multiple (w_multiple)
  );

  always_comb begin
    w_color_ganador = '0;
    for (int i = 0; i < N_CAPAS; i++) begin
      if (w_indice == c_ancho_id'(i))
        w_color_ganador = r_color_s1[i*ANCHO_RGB +: ANCHO_RGB];
    end

    w_rgb_next = '0;
    w_id_next  = c_ancho_id'(N_CAPAS);
    w_col_next = 1'b0;
    if (r_video_s1) begin
      w_rgb_next = w_hay_capa ? w_color_ganador : r_fondo_activo;
      w_id_next  = w_indice;
      w_col_next = w_multiple;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb      <= '0;
      r_id       <= c_ancho_id'(N_CAPAS);
      r_colision <= 1'b0;
    end else begin
      r_rgb      <= w_rgb_next;
      r_id       <= w_id_next;
      r_colision <= w_col_next;
    end
  end

  // Background: shadow is written any time, promoted at frame_tick. A write
  // coinciding with frame_tick bypasses the shadow into the active copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fondo_sombra <= FONDO_INICIAL;
      r_fondo_activo <= FONDO_INICIAL;
    end else if (bus.fondo_wr && bus.frame_tick) begin
      r_fondo_sombra <= bus.fondo_color;
      r_fondo_activo <= bus.fondo_color;
    end else if (bus.fondo_wr) begin
      r_fondo_sombra <= bus.fondo_color;
    end else if (bus.frame_tick) begin
      r_fondo_activo <= r_fondo_sombra;
    end
  end

  // A collision registered on the frame_tick edge belongs to the new frame,
  // so it seeds the freshly cleared latch instead of the reported flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_colision_frame <= 1'b0;
      r_latch_colision <= 1'b0;
    end else if (bus.frame_tick) begin
      r_colision_frame <= r_latch_colision;
      r_latch_colision <= w_col_next;
    end else if (w_col_next) begin
      r_latch_colision <= 1'b1;
    end
  end

  assign bus.rgb_salida     = r_rgb;
  assign bus.capa_id        = r_id;
  assign bus.colision       = r_colision;
  assign bus.colision_frame = r_colision_frame;

endmodule : mux_rgb_capas

`default_nettype wire

// File: tb/tb_mux_rgb_capas.sv
//------------------------------------------------------------------------------
// Module   : tb_mux_rgb_capas
// Purpose  : Directed self-checking bench for mux_rgb_capas (4 layers, 8-bit
//            colour, blink half-period 2 frames when MUX_RGB_PARPADEO_EN).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux_rgb_capas;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mux_rgb_capas_if #(.N_CAPAS(4), .ANCHO_RGB(8)) bus ();

  mux_rgb_capas #(
    .N_CAPAS          (4),
    .ANCHO_RGB        (8),
    .PERIODO_PARPADEO (2),
    .FONDO_INICIAL    (8'hFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Inputs change 1 time unit after a rising edge; checks sample there too.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_px(input string tag, input logic [7:0] rgb, input logic [2:0] id,
                        input logic col);
    chk({tag, ".rgb"}, 32'(bus.rgb_salida), 32'(rgb));
    chk({tag, ".id"},  32'(bus.capa_id),    32'(id));
    chk({tag, ".col"}, 32'(bus.colision),   32'(col));
  endtask

  task automatic frame_pulse();
    bus.frame_tick = 1'b1;
    tick();
    bus.frame_tick = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    bus.video_on    = 1'b1;
    bus.frame_tick  = 1'b0;
    bus.capa_activa = 4'b0000;
    // L3=E0, L2=3F, L1=1C, L0=10
    bus.color_capa  = {8'hE0, 8'h3F, 8'h1C, 8'h10};
    bus.parpadeo_en = 4'b0000;
    bus.fondo_wr    = 1'b0;
    bus.fondo_color = 8'h00;

    // Reset state
    tick(2);
    chk_px("reset", 8'h00, 3'd4, 1'b0);
    chk("reset.colf", 32'(bus.colision_frame), 32'd0);

    // Background only
    reset = 1'b0;
    tick(2);
    chk_px("fondo_ini", 8'hFF, 3'd4, 1'b0);

    // Priority: layers 1 and 2 overlap, layer 1 wins
    bus.capa_activa = 4'b0110;
    tick(2);
    chk_px("l1l2", 8'h1C, 3'd1, 1'b1);
    bus.capa_activa = 4'b1111;
    tick(2);
    chk_px("all", 8'h10, 3'd0, 1'b1);
    bus.capa_activa = 4'b1000;
    tick(2);
    chk_px("l3", 8'hE0, 3'd3, 1'b0);

    // Sticky frame collision: reported after the closing tick, then cleared
    bus.capa_activa = 4'b0000;
    tick(2);
    frame_pulse();
    chk("colf_set", 32'(bus.colision_frame), 32'd1);
    tick(3);
    frame_pulse();
    chk("colf_clr", 32'(bus.colision_frame), 32'd0);

    // Collision on the frame_tick edge itself goes to the new frame
    bus.capa_activa = 4'b0011;
    tick();
    bus.capa_activa = 4'b0000;
    frame_pulse();
    chk("colf_edge_old", 32'(bus.colision_frame), 32'd0);
    chk("col_edge", 32'(bus.colision), 32'd1);
    tick(3);
    frame_pulse();
    chk("colf_edge_new", 32'(bus.colision_frame), 32'd1);

    // Background double buffering
    bus.fondo_wr    = 1'b1;
    bus.fondo_color = 8'h03;
    tick();
    bus.fondo_wr    = 1'b0;
    tick(2);
    chk("fondo_sombra", 32'(bus.rgb_salida), 32'h0FF);
    frame_pulse();
    tick(2);
    chk("fondo_tick", 32'(bus.rgb_salida), 32'h003);
    bus.fondo_wr    = 1'b1;
    bus.fondo_color = 8'h55;
    frame_pulse();
    bus.fondo_wr    = 1'b0;
    tick();
    chk("fondo_directo", 32'(bus.rgb_salida), 32'h055);

    // Blanking with every layer active
    bus.video_on    = 1'b0;
    bus.capa_activa = 4'b1111;
    tick(2);
    chk_px("blank", 8'h00, 3'd4, 1'b0);

    // Reset mid-line and recovery
    bus.video_on    = 1'b1;
    bus.capa_activa = 4'b0100;
    tick(2);
    chk_px("pre_rst", 8'h3F, 3'd2, 1'b0);
    reset = 1'b1;
    tick();
    chk_px("mid_rst", 8'h00, 3'd4, 1'b0);
    chk("mid_rst.colf", 32'(bus.colision_frame), 32'd0);
    reset = 1'b0;
    tick();
    chk("rst_rec1", 32'(bus.rgb_salida), 32'h000);
    tick();
    chk_px("rst_rec2", 8'h3F, 3'd2, 1'b0);
    bus.capa_activa = 4'b0000;
    tick(2);
    chk("rst_fondo", 32'(bus.rgb_salida), 32'h0FF);

    // Blink: layer 0 blinks over layer 1, half-period 2 frames
    bus.parpadeo_en = 4'b0001;
    bus.capa_activa = 4'b0011;
    for (int f = 0; f < 5; f++) begin
      tick(2);
`ifdef MUX_RGB_PARPADEO_EN
      if ((f / 2) % 2 == 1) chk_px($sformatf("blink_f%0d", f), 8'h1C, 3'd1, 1'b0);
      else                  chk_px($sformatf("blink_f%0d", f), 8'h10, 3'd0, 1'b1);
`else
      chk_px($sformatf("noblink_f%0d", f), 8'h10, 3'd0, 1'b1);
`endif
      frame_pulse();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_mux_rgb_capas

`default_nettype wire
